// File: rtl/clock_pkg.sv
// clock_pkg: shared key FSM states, key codes and helpers for the clock/time-set path.
// Hold-to-repeat support in key_debounce is enabled by defining KEY_AUTO_REPEAT_EN.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    REPEAT,
    RELEASE
  } key_state_t;

  localparam int         KEY_W    = 5;
  localparam logic [2:0] KEY_MODE = 3'd1;
  localparam logic [2:0] KEY_DEC  = 3'd2;
  localparam logic [2:0] KEY_SEL  = 3'd3;
  localparam logic [2:0] KEY_INC  = 3'd5;

  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 5'd1)) == '0);
  endfunction

  function automatic logic [2:0] onehot_to_code(input logic [KEY_W-1:0] v);
    logic [2:0] c;
    c = '0;
    unique case (1'b1)
      v[0]:    c = KEY_MODE;
      v[1]:    c = KEY_DEC;
      v[2]:    c = KEY_SEL;
      v[3]:    c = 3'd4;
      v[4]:    c = KEY_INC;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_debounce_sync2.sv
// sync2: parameterised-width two-flop synchroniser with synchronous reset.
// Brings the asynchronous push-button levels into the clk domain.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s2_q;
  logic [W-1:0] s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: sync, debounce and chord-reject five buttons into one-cycle key events.
// Define KEY_AUTO_REPEAT_EN to compile in hold-to-repeat (REPEAT state and timers).
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC      = 2_000_000,
  parameter int REPEAT_DELAY_CYC  = 50_000_000,
  parameter int REPEAT_PERIOD_CYC = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic [2:0]       key_code,
  output logic             key_held
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ?
                           DEBOUNCE_CYC : REPEAT_DELAY_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_PERIOD_CYC) ?
                           MAX_AB : REPEAT_PERIOD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD_CYC - 1);
`endif

  logic [KEY_W-1:0] ks;

  sync2 #(.W(KEY_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key),
    .q   (ks)
  );

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             key_valid_q, key_valid_d;
  logic [2:0]       key_code_q, key_code_d;
  logic             key_held_q, key_held_d;
  logic             fire;

  // Counter saturates so a long hold in PRESSED can never wrap into a false match.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    cand_d  = cand_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_onehot(ks)) begin
          cand_d  = ks;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (ks != cand_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (cnt_q == RD_LAST) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end
`endif
      end
`ifdef KEY_AUTO_REPEAT_EN
      REPEAT: begin
        if (ks != cand_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == RP_LAST) begin
          fire  = 1'b1;
          cnt_d = '0;
        end
      end
`endif
      RELEASE: begin
        if (ks == cand_q) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (ks != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    key_valid_d = fire;
    key_code_d  = fire ? onehot_to_code(cand_q) : 3'd0;
    key_held_d  = state_d inside {PRESSED, REPEAT, RELEASE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized episodes; expected events queued from press timing arithmetic.
// Repeat expectations follow KEY_AUTO_REPEAT_EN.
module tb_key_debounce;

  localparam int D   = 8;
  localparam int RD  = 40;
  localparam int RP  = 10;
  localparam int GAP = D + 8;
  localparam int BIG = 32'h7fffffff;

`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    int e;
    int code;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key = '0;
  logic       key_valid;
  logic [2:0] key_code;
  logic       key_held;

  int  ecnt    = 0;
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;
  bit  prev_v  = 1'b0;
  ev_t sb[$];

  key_debounce #(
    .DEBOUNCE_CYC      (D),
    .REPEAT_DELAY_CYC  (RD),
    .REPEAT_PERIOD_CYC (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit hit, got %0d edges want finish", ecnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d want %0d", nm, ecnt, act, exp);
    end
  endtask

  // A key captured at edge s and held for h cycles is seen by the debouncer
  // through edge s+h+1; events land D+2 edges after s, then RD, then every RP.
  task automatic plan(input int s, input int h, input int cut, input int code);
    int  t;
    bit  first;
    ev_t ev;
    t     = s + D + 2;
    first = 1'b1;
    while (t <= s + h + 1 && t <= cut) begin
      ev.e    = t;
      ev.code = code;
      sb.push_back(ev);
      if (!REP) break;
      t     = t + (first ? RD : RP);
      first = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [4:0] v, input int n);
    key = v;
    repeat (n) step();
  endtask

  task automatic press(input int k, input int h, input bit chk_held);
    int         s;
    logic [4:0] v;
    s = ecnt + 1;
    v = 5'b1 << k;
    plan(s, h, BIG, k + 1);
    hold(v, h);
    key = '0;
    for (int i = 0; i < GAP; i++) begin
      if (chk_held && h >= D + 1) begin
        if (ecnt == s + h + D + 1) chk("held_before_idle", key_held, 1);
        if (ecnt == s + h + D + 2) chk("held_after_idle", key_held, 0);
      end
      step();
    end
  endtask

  task automatic bounce(input int k, input int nb, input int hfin);
    for (int i = 0; i < nb; i++) begin
      hold(5'b1 << k, $urandom_range(1, D));
      hold('0, $urandom_range(1, 3));
    end
    press(k, hfin, 1'b1);
  endtask

  task automatic chord(input logic [4:0] p, input int n);
    hold(p, n);
    chk("chord_held", key_held, 0);
    hold('0, GAP);
  endtask

  task automatic second(input int k1, input int k2, input int a);
    int s;
    s = ecnt + 1;
    plan(s, a, BIG, k1 + 1);
    hold(5'b1 << k1, a);
    hold((5'b1 << k1) | (5'b1 << k2), $urandom_range(1, 20));
    hold(5'b1 << k2, $urandom_range(1, 40));
    hold('0, GAP);
    press(k2, 20, 1'b1);
  endtask

  task automatic rst_press(input int k, input int h, input int r);
    int s;
    int rr;
    s  = ecnt + 1;
    rr = s + r;
    plan(s, h, rr - 1, k + 1);
    plan(rr + 1, s + h - rr - 1, BIG, k + 1);
    key = 5'b1 << k;
    for (int i = 0; i < h; i++) begin
      if (ecnt + 1 == rr) rst = 1'b1;
      step();
      if (rst) begin
        rst = 1'b0;
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_held", key_held, 0);
      end
    end
    hold('0, GAP);
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      if (key_valid) begin
        chk("no_back_to_back", prev_v, 0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event @edge %0d: got code %0d want no event",
                   ecnt, key_code);
        end else begin
          ev = sb.pop_front();
          chk("event_edge", ecnt, ev.e);
          chk("event_code", key_code, ev.code);
          chk("held_at_event", key_held, 1);
        end
      end else begin
        chk("code_when_idle", key_code, 0);
      end
      prev_v = key_valid;
    end
  end

  initial begin
    int         ty, k, k2, h;
    logic [4:0] p;
    repeat (3) step();
    chk("reset_valid", key_valid, 0);
    chk("reset_code", key_code, 0);
    chk("reset_held", key_held, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    press(4, 30, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hold(5'b00010, 3);
      hold('0, 3);
    end
    press(1, 40, 1'b1);
    chord(5'b00101, 50);
    press(4, 100, 1'b1);
    second(3, 0, D + 6);
    rst_press(2, 40, D + 2 + 3);

    for (int n = 0; n < 30; n++) begin
      ty = $urandom_range(0, 4);
      k  = $urandom_range(0, 4);
      k2 = (k + $urandom_range(1, 4)) % 5;
      unique case (ty)
        0: press(k, $urandom_range(1, 120), 1'b1);
        1: bounce(k, $urandom_range(1, 5), $urandom_range(1, 80));
        2: begin
          p = 5'($urandom_range(0, 31));
          while ($countones(p) < 2) p = 5'($urandom_range(0, 31));
          chord(p, $urandom_range(1, 60));
        end
        3: second(k, k2, $urandom_range(D + 1, D + 60));
        default: begin
          h = $urandom_range(20, 90);
          rst_press(k, h, $urandom_range(1, h - 1));
        end
      endcase
    end

    hold('0, GAP);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
